// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: one shift-add or restoring shift-subtract step
// per cycle over magnitudes, followed by a sign fix-up pass and a result-register cycle.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             z,
   output logic             n,
   output logic             dz
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH);

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   state_t           state, state_nx;
   logic [CW-1:0]    cnt;
   logic             is_div;
   logic             sign_a, sign_b;
   logic [WIDTH:0]   mag_a, mag_b;
   logic [WIDTH:0]   rem;
   logic [WIDTH-1:0] quo;

   logic load, step, fixup, finish;

   // ---------------- control ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      busy     = 1'b0;
      load     = 1'b0;
      step     = 1'b0;
      fixup    = 1'b0;
      finish   = 1'b0;
      unique case (state)
         IDLE: if (start) begin
            load     = 1'b1;
            state_nx = RUN;
         end
         RUN: begin
            busy = 1'b1;
            // The final count slot applies sign correction instead of iterating.
            if (cnt == LAST) begin
               fixup    = 1'b1;
               state_nx = FIN;
            end else begin
               step = 1'b1;
            end
         end
         FIN: begin
            busy     = 1'b1;
            finish   = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // ---------------- operand magnitudes ----------------
   logic [WIDTH:0] a_ext, b_ext, a_abs, b_abs;

   always_comb begin
      a_ext = {op[0] & A[WIDTH-1], A};
      b_ext = {op[0] & B[WIDTH-1], B};
      a_abs = a_ext[WIDTH] ? -a_ext : a_ext;
      b_abs = b_ext[WIDTH] ? -b_ext : b_ext;
   end

   // ---------------- iteration and fix-up arithmetic ----------------
   logic [WIDTH:0]     mul_sum, div_sh, div_diff;
   logic               div_ge, neg_q;
   logic [2*WIDTH-1:0] prod, prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix, fix_hi, fix_lo;

   always_comb begin
      mul_sum  = rem + (quo[0] ? mag_a : '0);
      div_sh   = {rem[WIDTH-1:0], quo[WIDTH-1]};
      div_ge   = (div_sh >= mag_b);
      div_diff = div_sh - mag_b;

      neg_q    = sign_a ^ sign_b;
      prod     = {rem[WIDTH-1:0], quo};
      prod_fix = neg_q ? -prod : prod;
      quo_fix  = neg_q ? -quo : quo;
      rem_fix  = sign_a ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];

      if (is_div) begin
         // With a zero divisor every trial subtract succeeds, so the remainder
         // already rebuilds the dividend; only the quotient is forced.
         fix_hi = rem_fix;
         fix_lo = (mag_b == '0) ? '1 : quo_fix;
      end else begin
         fix_hi = prod_fix[2*WIDTH-1:WIDTH];
         fix_lo = prod_fix[WIDTH-1:0];
      end
   end

   // ---------------- datapath ----------------
   // NOTE: every register here, including operand storage, is reset so that an
   // aborted operation leaves nothing behind; state updates use <= throughout.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt    <= '0;
         is_div <= 1'b0;
         sign_a <= 1'b0;
         sign_b <= 1'b0;
         mag_a  <= '0;
         mag_b  <= '0;
         rem    <= '0;
         quo    <= '0;
      end else if (load) begin
         cnt    <= '0;
         is_div <= op[1];
         sign_a <= a_ext[WIDTH];
         sign_b <= b_ext[WIDTH];
         mag_a  <= a_abs;
         mag_b  <= b_abs;
         rem    <= '0;
         // Multiply shifts the multiplier out of quo; divide shifts the dividend out.
         quo    <= op[1] ? a_abs[WIDTH-1:0] : b_abs[WIDTH-1:0];
      end else if (step) begin
         cnt <= cnt + 1'b1;
         if (is_div) begin
            rem <= div_ge ? div_diff : div_sh;
            quo <= {quo[WIDTH-2:0], div_ge};
         end else begin
            rem <= mul_sum >> 1;
            quo <= {mul_sum[0], quo[WIDTH-1:1]};
         end
      end else if (fixup) begin
         rem <= {1'b0, fix_hi};
         quo <= fix_lo;
      end
   end

   // ---------------- result registers ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         done <= 1'b0;
         hi   <= '0;
         lo   <= '0;
         z    <= 1'b0;
         n    <= 1'b0;
         dz   <= 1'b0;
      end else begin
         done <= finish;
         if (finish) begin
            hi <= rem[WIDTH-1:0];
            lo <= quo;
            z  <= is_div ? (quo == '0) : ({rem[WIDTH-1:0], quo} == '0);
            n  <= is_div ? quo[WIDTH-1] : rem[WIDTH-1];
            dz <= is_div & (mag_b == '0);
         end
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (WIDTH=32): hand-computed results, flags,
// fixed 34-cycle latency, ignored busy-time start, back-to-back start and abort by reset.
module tb_muldiv_unit;

   localparam int W = 32;
   localparam logic [1:0] MULTU = 2'b00, MULT = 2'b01, DIVU = 2'b10, DIV = 2'b11;

   logic         clk = 1'b0;
   logic         reset, start;
   logic [1:0]   op;
   logic [W-1:0] A, B, hi, lo;
   logic         busy, done, z, n, dz;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   muldiv_unit #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
      .busy(busy), .done(done), .hi(hi), .lo(lo), .z(z), .n(n), .dz(dz)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Called at a negedge: drives start for exactly one sampling edge.
   task automatic launch(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      start = 1'b1; op = o; A = a; B = b;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0; A = '0; B = '0;
      check("busy_after_start", busy, 1);
   endtask

   // Counts edges after the start edge until done is seen; bounded.
   task automatic wait_done(output int lat);
      lat = 0;
      while (done !== 1'b1 && lat < 40) begin
         @(posedge clk);
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic run_op(input string tag, input logic [1:0] o,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo,
                         input logic [2:0] exp_znd);
      int lat;
      @(negedge clk);
      launch(o, a, b);
      wait_done(lat);
      check({tag, "_latency"}, lat, 34);
      check({tag, "_hi"}, hi, exp_hi);
      check({tag, "_lo"}, lo, exp_lo);
      check({tag, "_z_n_dz"}, {z, n, dz}, exp_znd);
   endtask

   initial begin
      int lat;
      int dones;
      reset = 1'b1; start = 1'b0; op = '0; A = '0; B = '0;
      @(negedge clk);
      check("reset_hi", hi, 0);
      check("reset_lo", lo, 0);
      check("reset_ctrl_flags", {busy, done, z, n, dz}, 0);
      reset = 1'b0;

      run_op("mult_neg3x5",  MULT,  32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1, 3'b010);
      run_op("multu_max",    MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 3'b010);
      @(negedge clk);
      check("done_one_cycle", done, 0);
      run_op("div_neg7_2",   DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 3'b010);
      run_op("div_min_m1",   DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 3'b010);
      run_op("div_7_neg2",   DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 3'b010);
      run_op("divu_100_7",   DIVU,  32'd100,       32'd7,        32'd2,         32'd14,        3'b000);
      run_op("divu_by_zero", DIVU,  32'h1234_5678, 32'd0,        32'h1234_5678, 32'hFFFF_FFFF, 3'b011);
      run_op("multu_zero",   MULTU, 32'd0,         32'd5,        32'd0,         32'd0,         3'b100);

      // Start ignored while busy, then a start in the done cycle.
      @(negedge clk);
      launch(MULTU, 32'd6, 32'd7);
      lat = 0;
      while (done !== 1'b1 && lat < 40) begin
         @(posedge clk);
         @(negedge clk);
         lat++;
         start = (lat == 10);
         if (lat == 10) begin
            op = MULTU; A = 32'd3; B = 32'd3;
         end
      end
      check("b2b_first_latency", lat, 34);
      check("b2b_first_hi", hi, 0);
      check("b2b_first_lo", lo, 42);
      check("b2b_first_z", z, 0);
      launch(MULTU, 32'd5, 32'd7);
      check("b2b_done_dropped", done, 0);
      wait_done(lat);
      check("b2b_second_latency", lat, 34);
      check("b2b_second_lo", lo, 35);

      // Abort a divide by reset.
      @(negedge clk);
      launch(DIV, 32'd1000, 32'd3);
      repeat (14) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("abort_hi", hi, 0);
      check("abort_lo", lo, 0);
      check("abort_ctrl_flags", {busy, done, z, n, dz}, 0);
      @(negedge clk);
      reset = 1'b0;
      dones = 0;
      repeat (40) begin
         @(negedge clk);
         if (done === 1'b1) dones++;
      end
      check("abort_no_done", dones, 0);
      check("abort_outputs_held", {hi, lo}, 0);

      run_op("mult_2x2_after_reset", MULT, 32'd2, 32'd2, 32'd0, 32'd4, 3'b000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
